cum_hist_engine: RTL and testbench

Parametrised cumulative-histogram engine for the histogram-equalisation path. Accepts one frame of `IMAGE_SIZE` pixels and counts them into a single RAM-based histogram using a read-modify-write pipeline. It then streams the cumulative distribution, bin 0 to bin 2^PIX_W−1, to the LUT builder over a valid/ready handshake. Compared with the one-counter-per-level cumulative calculator it replaces, it generalises pixel width, uses one memory instead of 2^PIX_W counters, adds backpressure and clears itself for back-to-back frames.

---
 rtl/cum_hist_engine_if.sv | 47 ++++
 rtl/cum_hist_engine.sv | 248 ++++++++++++++++++++++++
 tb/tb_cum_hist_engine.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cum_hist_engine_if.sv
// -----------------------------------------------------------------------------
// cum_hist_engine_if
// Bundles the two streams of the cumulative-histogram engine:
//   pixel stream : i_pixel_data / i_pixel_valid in, o_pixel_ready out
//   CDF stream   : o_cdf_valid / o_cdf_level / o_cdf_data / o_cdf_last out,
//                  i_cdf_ready in
// Signal names carry the engine's point of view (i_ = into the engine).
// modport slave  : the engine side
// modport master : the side that feeds pixels and consumes the CDF
// Optional build macro CUMHIST_EQ_EN adds o_eq_level (equalised level).
// -----------------------------------------------------------------------------
interface cum_hist_engine_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 19
);
  logic [PIX_W-1:0] i_pixel_data;
  logic             i_pixel_valid;
  logic             o_pixel_ready;
  logic             o_cdf_valid;
  logic             i_cdf_ready;
  logic [PIX_W-1:0] o_cdf_level;
  logic [CNT_W-1:0] o_cdf_data;
  logic             o_cdf_last;
`ifdef CUMHIST_EQ_EN
  logic [PIX_W-1:0] o_eq_level;

  modport slave (
    input  i_pixel_data, i_pixel_valid, i_cdf_ready,
    output o_pixel_ready, o_cdf_valid, o_cdf_level, o_cdf_data, o_cdf_last,
           o_eq_level
  );
  modport master (
    output i_pixel_data, i_pixel_valid, i_cdf_ready,
    input  o_pixel_ready, o_cdf_valid, o_cdf_level, o_cdf_data, o_cdf_last,
           o_eq_level
  );
`else
  modport slave (
    input  i_pixel_data, i_pixel_valid, i_cdf_ready,
    output o_pixel_ready, o_cdf_valid, o_cdf_level, o_cdf_data, o_cdf_last
  );
  modport master (
    output i_pixel_data, i_pixel_valid, i_cdf_ready,
    input  o_pixel_ready, o_cdf_valid, o_cdf_level, o_cdf_data, o_cdf_last
  );
`endif
endinterface

// File: rtl/cum_hist_engine.sv
// -----------------------------------------------------------------------------
// cum_hist_engine
// Counts one frame of IMAGE_SIZE pixels into a RAM histogram (read-modify-write
// pipeline with forwarding, 1 pixel/cycle), then streams the cumulative
// distribution bin 0..NBINS-1 over valid/ready. Bins are zeroed as they are
// scanned, so back-to-back frames need no separate clear pass.
// Ports:
//   i_clk    : clock, rising edge
//   i_reset  : synchronous active-high reset (goes to CLEAR)
//   bus      : cum_hist_engine_if.slave (pixel stream in, CDF stream out)
//   o_busy   : high in CLEAR, DRAIN and SCAN
// Build option: define CUMHIST_EQ_EN to add bus.o_eq_level =
//   floor(o_cdf_data * (NBINS-1) / IMAGE_SIZE).
// -----------------------------------------------------------------------------
module cum_hist_engine #(
  parameter int PIX_W      = 8,
  parameter int IMAGE_SIZE = 640*480,
  parameter int CNT_W      = $clog2(IMAGE_SIZE+1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  cum_hist_engine_if.slave      bus,
  output logic                  o_busy
);
  localparam int               NBINS     = 1 << PIX_W;
  localparam logic [PIX_W-1:0] LAST_BIN  = PIX_W'(NBINS-1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(IMAGE_SIZE);

  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_SCAN} state_t;

  // Histogram RAM: one write port, one registered read port.
  logic [CNT_W-1:0] mem [NBINS];
  logic [CNT_W-1:0] rdata_q;
  logic             rd_en, wr_en;
  logic [PIX_W-1:0] rd_addr, wr_addr;
  logic [CNT_W-1:0] wr_data;

  state_t           state_q, state_d;
  logic             pixel_ready_q, pixel_ready_d;
  logic             busy_q, busy_d;
  logic [PIX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // RMW pipeline: s1 = read returned, s2 = incremented value being written,
  // s3 = value written on the previous edge (missed by a same-edge read).
  logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic [PIX_W-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d, s3_addr_q, s3_addr_d;
  logic [CNT_W-1:0] s2_data_q, s2_data_d, s3_data_q, s3_data_d;

  // Scan side: read issue pointer, one outstanding read, running sum.
  logic [PIX_W-1:0] scan_ptr_q, scan_ptr_d;
  logic             scan_done_q, scan_done_d;
  logic             pend_valid_q, pend_valid_d;
  logic [PIX_W-1:0] pend_level_q, pend_level_d;
  logic [CNT_W-1:0] sum_q, sum_d;

  // Two-entry output skid; head drives the outputs directly.
  logic             head_valid_q, head_valid_d, tail_valid_q, tail_valid_d;
  logic [PIX_W-1:0] head_level_q, head_level_d, tail_level_q, tail_level_d;
  logic [CNT_W-1:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic             head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic             accept, pop;
  logic [CNT_W-1:0] base, push_data;
  logic [1:0]       occ;

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    scan_ptr_d   = scan_ptr_q;
    scan_done_d  = scan_done_q;
    pend_level_d = pend_level_q;
    sum_d        = sum_q;
    head_valid_d = head_valid_q;
    head_level_d = head_level_q;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    tail_valid_d = tail_valid_q;
    tail_level_d = tail_level_q;
    tail_data_d  = tail_data_q;
    tail_last_d  = tail_last_q;
    rd_en        = 1'b0;
    rd_addr      = bus.i_pixel_data;
    wr_en        = 1'b0;
    wr_addr      = clr_ptr_q;
    wr_data      = '0;
    push_data    = '0;

    accept = bus.i_pixel_valid & pixel_ready_q;
    pop    = head_valid_q & bus.i_cdf_ready;

    // RMW: newest in-flight value of the same bin wins over the RAM data.
    if (s2_valid_q && (s2_addr_q == s1_addr_q))      base = s2_data_q;
    else if (s3_valid_q && (s3_addr_q == s1_addr_q)) base = s3_data_q;
    else                                             base = rdata_q;

    s1_valid_d = accept;
    s1_addr_d  = bus.i_pixel_data;
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = base + CNT_W'(1);
    s3_valid_d = s2_valid_q;
    s3_addr_d  = s2_addr_q;
    s3_data_d  = s2_data_q;
    if (s2_valid_q) begin
      wr_en   = 1'b1;
      wr_addr = s2_addr_q;
      wr_data = s2_data_q;
    end

    // Skid pop, then push of the read that returned this cycle.
    if (pop) begin
      head_valid_d = tail_valid_q;
      head_level_d = tail_level_q;
      head_data_d  = tail_data_q;
      head_last_d  = tail_last_q;
      tail_valid_d = 1'b0;
    end
    if (pend_valid_q) begin
      push_data = sum_q + rdata_q;
      sum_d     = push_data;
      wr_en     = 1'b1;               // bin read out, zero it for the next frame
      wr_addr   = pend_level_q;
      wr_data   = '0;
      if (!head_valid_d) begin
        head_valid_d = 1'b1;
        head_level_d = pend_level_q;
        head_data_d  = push_data;
        head_last_d  = (pend_level_q == LAST_BIN);
      end else begin
        tail_valid_d = 1'b1;
        tail_level_d = pend_level_q;
        tail_data_d  = push_data;
        tail_last_d  = (pend_level_q == LAST_BIN);
      end
    end

    // Only issue a read when the skid is guaranteed room for its result.
    occ = 2'(head_valid_q) + 2'(tail_valid_q) + 2'(pend_valid_q) - 2'(pop);
    pend_valid_d = 1'b0;
    if (accept) begin
      rd_en   = 1'b1;
      rd_addr = bus.i_pixel_data;
    end else if ((state_q == S_SCAN) && !scan_done_q && (occ < 2'd2)) begin
      rd_en        = 1'b1;
      rd_addr      = scan_ptr_q;
      pend_valid_d = 1'b1;
      pend_level_d = scan_ptr_q;
      scan_ptr_d   = scan_ptr_q + PIX_W'(1);
      if (scan_ptr_q == LAST_BIN) scan_done_d = 1'b1;
    end

    case (state_q)
      S_CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_ptr_q;
        wr_data   = '0;
        clr_ptr_d = clr_ptr_q + PIX_W'(1);
        if (clr_ptr_q == LAST_BIN) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (accept) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          if (frame_cnt_d == FRAME_END) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Once s1 is empty the last write lands on this edge, before the
        // first scan read one edge later.
        if (!s1_valid_q) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (pop && head_last_q) begin
          state_d     = S_ACCUM;
          frame_cnt_d = '0;
          sum_d       = '0;
          scan_ptr_d  = '0;
          scan_done_d = 1'b0;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    pixel_ready_d = (state_d == S_ACCUM);
    busy_d        = (state_d != S_ACCUM);
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_CLEAR;
      pixel_ready_q <= 1'b0;
      busy_q        <= 1'b1;
      clr_ptr_q     <= '0;
      frame_cnt_q   <= '0;
      s1_valid_q    <= 1'b0;  s1_addr_q <= '0;
      s2_valid_q    <= 1'b0;  s2_addr_q <= '0;  s2_data_q <= '0;
      s3_valid_q    <= 1'b0;  s3_addr_q <= '0;  s3_data_q <= '0;
      scan_ptr_q    <= '0;
      scan_done_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_level_q  <= '0;
      sum_q         <= '0;
      head_valid_q  <= 1'b0;  head_level_q <= '0;  head_data_q <= '0;  head_last_q <= 1'b0;
      tail_valid_q  <= 1'b0;  tail_level_q <= '0;  tail_data_q <= '0;  tail_last_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pixel_ready_q <= pixel_ready_d;
      busy_q        <= busy_d;
      clr_ptr_q     <= clr_ptr_d;
      frame_cnt_q   <= frame_cnt_d;
      s1_valid_q    <= s1_valid_d;  s1_addr_q <= s1_addr_d;
      s2_valid_q    <= s2_valid_d;  s2_addr_q <= s2_addr_d;  s2_data_q <= s2_data_d;
      s3_valid_q    <= s3_valid_d;  s3_addr_q <= s3_addr_d;  s3_data_q <= s3_data_d;
      scan_ptr_q    <= scan_ptr_d;
      scan_done_q   <= scan_done_d;
      pend_valid_q  <= pend_valid_d;
      pend_level_q  <= pend_level_d;
      sum_q         <= sum_d;
      head_valid_q  <= head_valid_d;  head_level_q <= head_level_d;
      head_data_q   <= head_data_d;   head_last_q  <= head_last_d;
      tail_valid_q  <= tail_valid_d;  tail_level_q <= tail_level_d;
      tail_data_q   <= tail_data_d;   tail_last_q  <= tail_last_d;
    end
  end

  assign bus.o_pixel_ready = pixel_ready_q;
  assign bus.o_cdf_valid   = head_valid_q;
  assign bus.o_cdf_level   = head_level_q;
  assign bus.o_cdf_data    = head_data_q;
  assign bus.o_cdf_last    = head_last_q;
  assign o_busy            = busy_q;

`ifdef CUMHIST_EQ_EN
  localparam int PROD_W = CNT_W + PIX_W;
  logic [PROD_W-1:0] eq_prod, eq_quot;
  always_comb begin
    eq_prod = PROD_W'(head_data_q) * PROD_W'(NBINS-1);
    eq_quot = eq_prod / PROD_W'(IMAGE_SIZE);
  end
  assign bus.o_eq_level = eq_quot[PIX_W-1:0];
`endif
endmodule

// File: tb/tb_cum_hist_engine.sv
`timescale 1ns/1ps
module tb_cum_hist_engine;
  localparam int PIX_W      = 8;
  localparam int IMAGE_SIZE = 256;
  localparam int CNT_W      = $clog2(IMAGE_SIZE+1);
  localparam int NBINS      = 1 << PIX_W;
  localparam int BUDGET     = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  cum_hist_engine_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

  cum_hist_engine #(.PIX_W(PIX_W), .IMAGE_SIZE(IMAGE_SIZE), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus),
    .o_busy  (busy)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: histogram of the frame's pixel list, then prefix sums.
  int pix_q[$];
  int exp_cdf[NBINS];

  task automatic gen_frame(input int mode, input int c);
    int hist[NBINS];
    int run, j, tmp;
    pix_q.delete();
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      case (mode)
        0, 5:    pix_q.push_back(i % NBINS);
        1:       pix_q.push_back(c);
        2:       pix_q.push_back((i % 2 == 0) ? 3 : 4);
        3:       pix_q.push_back(int'($urandom_range(NBINS-1)));
        default: pix_q.push_back(int'($urandom_range(3)));
      endcase
    end
    if (mode == 5) begin
      for (int i = IMAGE_SIZE-1; i > 0; i--) begin
        j = int'($urandom_range(i));
        tmp = pix_q[i]; pix_q[i] = pix_q[j]; pix_q[j] = tmp;
      end
    end
    for (int k = 0; k < NBINS; k++) hist[k] = 0;
    foreach (pix_q[i]) hist[pix_q[i]]++;
    run = 0;
    for (int k = 0; k < NBINS; k++) begin
      run += hist[k];
      exp_cdf[k] = run;
    end
  endtask

  // Expects to be called between edges; reset is held for exactly one edge.
  task automatic apply_reset();
    int  n;
    bit  saw_valid;
    rst = 1'b1;
    bus.i_pixel_valid = 1'b0;
    bus.i_cdf_ready   = 1'b0;
    @(posedge clk); #1;
    check_val("rst_pixel_ready", bus.o_pixel_ready, 0);
    check_val("rst_cdf_valid",   bus.o_cdf_valid, 0);
    check_val("rst_cdf_last",    bus.o_cdf_last, 0);
    check_val("rst_cdf_level",   bus.o_cdf_level, 0);
    check_val("rst_cdf_data",    bus.o_cdf_data, 0);
    check_val("rst_busy",        busy, 1);
`ifdef CUMHIST_EQ_EN
    check_val("rst_eq_level",    bus.o_eq_level, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    saw_valid = 1'b0;
    // A few garbage pixels while not ready; they must not be counted.
    bus.i_pixel_valid = 1'b1;
    while (n < 2*NBINS) begin
      @(negedge clk);
      n++;
      bus.i_pixel_data = PIX_W'($urandom);
      if (bus.o_cdf_valid) saw_valid = 1'b1;
      if (bus.o_pixel_ready) break;
    end
    bus.i_pixel_valid = 1'b0;
    check_val("ready_after_reset_cycles", n, NBINS);
    check_val("beat_during_clear", saw_valid, 0);
    check_val("busy_after_clear", busy, 0);
    $display("reset: ready after %0d cycles", n);
  endtask

  // abort: 0 none, 1 reset after half the frame, 2 reset mid-scan
  task automatic run_frame(input string name, input int vpct, input int rpct,
                           input int abort, input bit timing);
    int idx = 0, beat = 0, cyc = 0;
    int acc_cyc = -1, first_valid_cyc = -1, first_beat_cyc = -1, last_beat_cyc = -1;
    bit stall = 1'b0, done = 1'b0, aborted = 1'b0, rdy;
    logic [PIX_W-1:0] sv_level;
    logic [CNT_W-1:0] sv_data;
    logic             sv_last;
    @(negedge clk);
    check_val({name, "_start_ready"}, bus.o_pixel_ready, 1);
    check_val({name, "_start_busy"}, busy, 0);
    while (!done && cyc < BUDGET) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (stall) begin
        check_val({name, "_hold_valid"}, bus.o_cdf_valid, 1);
        check_val({name, "_hold_level"}, bus.o_cdf_level, sv_level);
        check_val({name, "_hold_data"},  bus.o_cdf_data, sv_data);
        check_val({name, "_hold_last"},  bus.o_cdf_last, sv_last);
      end
      if (bus.o_cdf_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.o_cdf_valid && idx < IMAGE_SIZE) check_val({name, "_early_beat"}, 1, 0);
      if ((abort == 1 && idx == IMAGE_SIZE/2) || (abort == 2 && beat == NBINS/2)) begin
        aborted = 1'b1;
        break;
      end
      if (bus.o_pixel_ready && idx < IMAGE_SIZE && int'($urandom_range(99)) < vpct) begin
        bus.i_pixel_valid = 1'b1;
        bus.i_pixel_data  = PIX_W'(pix_q[idx]);
        idx++;
        if (idx == IMAGE_SIZE) acc_cyc = cyc;
      end else if (bus.o_pixel_ready) begin
        bus.i_pixel_valid = 1'b0;
        bus.i_pixel_data  = PIX_W'($urandom);
      end else begin
        bus.i_pixel_valid = 1'($urandom_range(1));
        bus.i_pixel_data  = PIX_W'($urandom);
      end
      rdy = (int'($urandom_range(99)) < rpct);
      bus.i_cdf_ready = rdy;
      if (bus.o_cdf_valid && rdy) begin
        check_val({name, "_level"}, bus.o_cdf_level, beat);
        check_val({name, "_data"},  bus.o_cdf_data, exp_cdf[beat]);
        check_val({name, "_last"},  bus.o_cdf_last, (beat == NBINS-1));
`ifdef CUMHIST_EQ_EN
        check_val({name, "_eq"}, bus.o_eq_level, (exp_cdf[beat] * (NBINS-1)) / IMAGE_SIZE);
`endif
        if (first_beat_cyc < 0) begin
          first_beat_cyc = cyc;
          check_val({name, "_busy_scan"}, busy, 1);
        end
        last_beat_cyc = cyc;
        beat++;
        if (beat == NBINS) done = 1'b1;
      end
      stall    = bus.o_cdf_valid && !rdy;
      sv_level = bus.o_cdf_level;
      sv_data  = bus.o_cdf_data;
      sv_last  = bus.o_cdf_last;
    end
    if (aborted) begin
      $display("frame %s: aborted after %0d pixels, %0d beats", name, idx, beat);
      apply_reset();
    end else if (!done) begin
      check_val({name, "_timeout_beats"}, beat, NBINS);
      apply_reset();
    end else begin
      @(posedge clk); #1;
      bus.i_pixel_valid = 1'b0;
      bus.i_cdf_ready   = 1'b0;
      check_val({name, "_ready_after_last"}, bus.o_pixel_ready, 1);
      check_val({name, "_busy_after_last"}, busy, 0);
      if (timing) begin
        check_val({name, "_first_valid_latency_le5"}, (first_valid_cyc - acc_cyc) <= 5, 1);
        check_val({name, "_stream_span"}, last_beat_cyc - first_beat_cyc, NBINS-1);
      end
      $display("frame %s: %0d pixels, %0d beats, %0d cycles, final cdf %0d",
               name, idx, beat, cyc, exp_cdf[NBINS-1]);
    end
  endtask

  initial begin
    bus.i_pixel_valid = 1'b0;
    bus.i_pixel_data  = '0;
    bus.i_cdf_ready   = 1'b0;
    apply_reset();
    gen_frame(0, 0);   run_frame("uniform",      100, 100, 0, 1'b1);
    gen_frame(1, 7);   run_frame("all7",         100, 100, 0, 1'b1);
    gen_frame(2, 0);   run_frame("abab",         100,  30, 0, 1'b0);
    gen_frame(1, 0);   run_frame("all0",         100, 100, 0, 1'b1);
    gen_frame(1, 255); run_frame("all255",       100, 100, 0, 1'b1);
    gen_frame(4, 0);   run_frame("small_rand",   100,  60, 0, 1'b0);
    gen_frame(3, 0);   run_frame("abort_half",    70,  50, 1, 1'b0);
    gen_frame(3, 0);   run_frame("after_abort1",  80,  70, 0, 1'b0);
    gen_frame(3, 0);   run_frame("abort_scan",   100,  50, 2, 1'b0);
    gen_frame(4, 0);   run_frame("after_abort2",  90,  40, 0, 1'b0);
    gen_frame(5, 0);   run_frame("shuffled",      50,  20, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
